// File: rtl/conv_pkg.sv
// Shared definitions for the line-window read side.
//   NBANK      : number of line-buffer banks
//   KWIN       : window edge length (3x3 window)
//   rd_state_e : read-side controller states
//   bank_inc   : bank index step with 2-bit wrap
//   bank_onehot: one-hot mask for a bank index
package conv_pkg;

    localparam int NBANK = 4;
    localparam int KWIN  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        SCAN    = 2'd2,
        RELEASE = 2'd3
    } rd_state_e;

    // Bank indices wrap naturally in 2-bit arithmetic.
    function automatic logic [1:0] bank_inc(input logic [1:0] bank, input logic [1:0] step);
        return bank + step;
    endfunction

    function automatic logic [NBANK-1:0] bank_onehot(input logic [1:0] bank);
        logic [NBANK-1:0] mask;
        mask       = '0;
        mask[bank] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/line_window_reader_if.sv
// Window stream between the line-window reader and the convolution datapath.
//   win_valid  : window valid (source -> sink)
//   win_ready  : sink accepts the window (sink -> source)
//   win_data   : 3x3 window, row-major, top-left pixel in the low PB bits
//   win_row    : image row of the window centre
//   win_col    : image column of the window centre
//   frame_done : one-cycle pulse at the end of a frame
interface line_window_reader_if
    import conv_pkg::*;
#(
    parameter int XB = 10,
    parameter int YB = 10,
    parameter int PB = 8
);
    logic                     win_valid;
    logic                     win_ready;
    logic [KWIN*KWIN*PB-1:0]  win_data;
    logic [YB-1:0]            win_row;
    logic [XB-1:0]            win_col;
    logic                     frame_done;

    modport master (
        output win_valid, win_data, win_row, win_col, frame_done,
        input  win_ready
    );

    modport slave (
        input  win_valid, win_data, win_row, win_col, frame_done,
        output win_ready
    );
endinterface

// File: rtl/win_shift3x3.sv
// 3x3 pixel window shift register.
//   clk, rst  : clock, asynchronous active-low reset
//   shift_en  : shift the window one column left and load col_in on the right
//   col_in    : new column, index 0 = top row
//   win_out   : packed window, row-major, top-left pixel in bits [PB-1:0]
module win_shift3x3
    import conv_pkg::*;
#(
    parameter int PB = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    shift_en,
    input  logic [PB-1:0]           col_in [KWIN],
    output logic [KWIN*KWIN*PB-1:0] win_out
);

    genvar gi, gj;

    generate
        for (gi = 0; gi < KWIN; gi++) begin : g_row
            // tap_reg[0] is the leftmost (oldest) column of this window row.
            logic [PB-1:0] tap_reg [KWIN];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < KWIN; k++) begin
                        tap_reg[k] <= '0;
                    end
                end else if (shift_en) begin
                    for (int k = 0; k < KWIN - 1; k++) begin
                        tap_reg[k] <= tap_reg[k+1];
                    end
                    tap_reg[KWIN-1] <= col_in[gi];
                end
            end

            for (gj = 0; gj < KWIN; gj++) begin : g_tap
                assign win_out[(gi*KWIN+gj)*PB +: PB] = tap_reg[gj];
            end
        end
    endgenerate

endmodule

// File: rtl/line_window_reader.sv
// Read side of the 4-bank line buffer.
// Tracks which banks the fill side has completed, scans three consecutive
// filled banks column by column and streams 3x3 windows with valid/ready
// backpressure. Each bank is handed back with a one-cycle mem_used pulse once
// its last window row has been consumed.
//   clk, rst      : clock, asynchronous active-low reset
//   cfg_width     : pixels per row (>= 3, stable while active)
//   cfg_height    : rows per frame (>= 3, stable while active)
//   mem_bank_full : per-bank full level from the fill side
//   mem_used      : per-bank one-cycle release pulse
//   mb_rd_addr    : per-bank read address (synchronous read, 1-cycle latency)
//   pix_data      : per-bank read data
//   win           : window stream (master side)
module line_window_reader
    import conv_pkg::*;
#(
    parameter int XB = 10,
    parameter int YB = 10,
    parameter int PB = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XB-1:0]    cfg_width,
    input  logic [YB-1:0]    cfg_height,
    input  logic [NBANK-1:0] mem_bank_full,
    output logic [NBANK-1:0] mem_used,
    output logic [XB-1:0]    mb_rd_addr [NBANK-1:0],
    input  logic [PB-1:0]    pix_data   [NBANK-1:0],
    line_window_reader_if.master win
);

    rd_state_e               state_reg, state_next;
    logic [1:0]              bp_reg;
    logic [NBANK-1:0]        ready_reg;
    logic [NBANK-1:0]        full_d_reg;
    logic [XB-1:0]           col_reg;
    logic                    pending_reg;
    logic                    row_done_reg;
    logic [YB-1:0]           out_row_reg;
    logic                    win_valid_reg;
    logic [XB-1:0]           win_col_reg;
    logic [YB-1:0]           win_row_reg;

    logic [1:0]              bank_mid, bank_bot, bank_idle;
    logic                    banks_ready, shift, hs, col_last, last_row;
    logic [NBANK-1:0]        release_mask;
    logic                    frame_done_c;
    logic [PB-1:0]           col_pix [KWIN];
    logic [KWIN*KWIN*PB-1:0] win_data_w;

    assign bank_mid  = bank_inc(bp_reg, 2'd1);
    assign bank_bot  = bank_inc(bp_reg, 2'd2);
    assign bank_idle = bank_inc(bp_reg, 2'd3);

    assign banks_ready = ready_reg[bp_reg] & ready_reg[bank_mid] & ready_reg[bank_bot];
    assign hs          = win_valid_reg & win.win_ready;
    // Advance whenever the output slot is free or being emptied this cycle.
    assign shift       = (state_reg == SCAN) & pending_reg & (~win_valid_reg | win.win_ready);
    assign col_last    = (col_reg == cfg_width - XB'(1));
    assign last_row    = (out_row_reg >= cfg_height - YB'(3));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = WAIT;
            WAIT:    if (banks_ready) state_next = SCAN;
            SCAN:    if (row_done_reg && hs) state_next = RELEASE;
            RELEASE: state_next = last_row ? IDLE : WAIT;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // On the last row all three active banks go back at once; that is every
    // bank except the idle one.
    always_comb begin
        release_mask = '0;
        frame_done_c = 1'b0;
        if (state_reg == RELEASE) begin
            if (last_row) begin
                release_mask = ~bank_onehot(bank_idle);
                frame_done_c = 1'b1;
            end else begin
                release_mask = bank_onehot(bp_reg);
            end
        end
    end

    assign mem_used       = release_mask;
    assign win.frame_done = frame_done_c;

    // ---------------- Read addresses and column input ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NBANK; gi++) begin : g_addr
            // During a shift the next column is requested so its data lands
            // exactly when the following shift needs it.
            assign mb_rd_addr[gi] = (state_reg == SCAN && bank_idle != 2'(gi)) ?
                                    (shift ? col_reg + XB'(1) : col_reg) : '0;
        end
        for (gi = 0; gi < KWIN; gi++) begin : g_col
            assign col_pix[gi] = pix_data[bank_inc(bp_reg, 2'(gi))];
        end
    endgenerate

    win_shift3x3 #(.PB(PB)) u_shift (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift),
        .col_in   (col_pix),
        .win_out  (win_data_w)
    );

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bp_reg        <= '0;
            ready_reg     <= '0;
            full_d_reg    <= '0;
            col_reg       <= '0;
            pending_reg   <= 1'b0;
            row_done_reg  <= 1'b0;
            out_row_reg   <= '0;
            win_valid_reg <= 1'b0;
            win_col_reg   <= '0;
            win_row_reg   <= '0;
        end else begin
            full_d_reg <= mem_bank_full;
            // A new fill completion wins over a same-cycle release.
            ready_reg  <= (ready_reg & ~release_mask) | (mem_bank_full & ~full_d_reg);

            if (state_reg == WAIT && banks_ready) begin
                col_reg      <= '0;
                pending_reg  <= 1'b0;
                row_done_reg <= 1'b0;
            end else if (state_reg == SCAN) begin
                if (shift) begin
                    col_reg <= col_reg + XB'(1);
                    if (col_last) begin
                        pending_reg  <= 1'b0;
                        row_done_reg <= 1'b1;
                    end
                end else if (!row_done_reg) begin
                    // First SCAN cycle only issues column 0's address.
                    pending_reg <= 1'b1;
                end
            end

            // Columns 0 and 1 only prime the window.
            if (shift && col_reg >= XB'(2)) begin
                win_valid_reg <= 1'b1;
                win_col_reg   <= col_reg - XB'(1);
                win_row_reg   <= out_row_reg + YB'(1);
            end else if (hs) begin
                win_valid_reg <= 1'b0;
            end

            if (state_reg == RELEASE) begin
                bp_reg      <= bank_inc(bp_reg, last_row ? 2'd3 : 2'd1);
                out_row_reg <= last_row ? '0 : out_row_reg + YB'(1);
            end
        end
    end

    assign win.win_valid = win_valid_reg;
    assign win.win_data  = win_data_w;
    assign win.win_col   = win_col_reg;
    assign win.win_row   = win_row_reg;

endmodule
